// File: rtl/swd_seq_capture_pkg.sv
// rtl/swd_seq_capture_pkg.sv - shared definitions for the SWD sequence capture engine
//
// Contents:
//   seq_state_t    capture FSM states IDLE/TURN/LOW/HIGH/DONE
//   SEQ_MAX        maximum bits per capture command (64-bit data path)
//   FLAG_*         rx_flag field positions
//   clamp_count()  maps a raw cmd_count onto the effective bit count 1..64
package swd_seq_capture_pkg;

    localparam int SEQ_MAX       = 64;
    localparam int CNT_W         = 7;

    localparam int FLAG_CNT_LSB  = 0;
    localparam int FLAG_CNT_MSB  = 6;
    localparam int FLAG_TURN_BIT = 15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TURN = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        DONE = 3'd4
    } seq_state_t;

    // 0 means a full word; anything beyond the data path width is clamped to it.
    function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] raw);
        if (raw == '0 || raw > CNT_W'(SEQ_MAX)) begin
            return CNT_W'(SEQ_MAX);
        end
        return raw;
    endfunction

endpackage

// File: rtl/swd_seq_capture_half_div.sv
// rtl/swd_seq_capture_half_div.sv - SWCLK half-period counter with terminal-count strobe
//
// Module swclk_half_div
//   DIV    clk cycles per SWCLK half-period (1..255)
//   clk    controller clock
//   reset  synchronous active-high reset
//   clear  restart the count from 0 (command accept)
//   run    count while high; held at 0 while low
//   tc     one-cycle strobe in the last cycle of each half-period
module swclk_half_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tc
);

    localparam logic [7:0] DIV_M1 = 8'(DIV - 1);

    logic [7:0] cnt_q;

    assign tc = run && (cnt_q == DIV_M1);

    always_ff @(posedge clk) begin
        if (reset || clear || !run) begin
            cnt_q <= '0;
        end else if (tc) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

endmodule

// File: rtl/swd_seq_capture.sv
// rtl/swd_seq_capture.sv - SWD read-direction sequence capture engine
//
// Captures 1..64 bits from SWDIO LSB-first while generating SWCLK bursts and
// returns the word over a valid/ready result channel.
// Optional build macro: SEQ_CAPTURE_TURN_EN inserts one unsampled SWCLK period
// (turnaround) before the first sample and sets rx_flag[15].
//
// Ports:
//   clk, reset     controller clock, synchronous active-high reset
//   cmd_valid/ready/count   capture request (count 0 or >64 -> 64)
//   rx_valid/ready/data/flag  result channel; flag[6:0] = bit count
//   busy           high from accept until result handshake
//   SWCLK_TCK_O    generated serial clock, idles low
//   SWDIO_TMS_T    SWDIO tristate control, 1 = released
//   SWDIO_TMS_I    SWDIO line input (already synchronised)
module swd_seq_capture
    import swd_seq_capture_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_count,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [63:0] rx_data,
    output logic [15:0] rx_flag,
    output logic        busy,
    output logic        SWCLK_TCK_O,
    output logic        SWDIO_TMS_T,
    input  logic        SWDIO_TMS_I
);

`ifdef SEQ_CAPTURE_TURN_EN
    localparam logic       TURN_EN     = 1'b1;
    localparam seq_state_t FIRST_PHASE = TURN;
`else
    localparam logic       TURN_EN     = 1'b0;
    localparam seq_state_t FIRST_PHASE = LOW;
`endif

    seq_state_t         state_q, state_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   bit_idx_q;
    logic [SEQ_MAX-1:0] shift_q;
    logic               swclk_q;
    logic               busy_q;
    logic               rx_valid_q;
    logic [63:0]        rx_data_q;
    logic [15:0]        rx_flag_q;
    logic [15:0]        flag_d;
    logic               accept;
    logic               half_run;
    logic               half_tc;

    assign cmd_ready   = (state_q == IDLE) && !rx_valid_q;
    assign accept      = cmd_valid && cmd_ready;
    assign half_run    = (state_q == TURN) || (state_q == LOW) || (state_q == HIGH);

    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_flag     = rx_flag_q;
    assign busy        = busy_q;
    assign SWCLK_TCK_O = swclk_q;
    // This engine only reads the line, so SWDIO is never driven.
    assign SWDIO_TMS_T = 1'b1;

    swclk_half_div #(
        .DIV (CLK_DIV)
    ) u_half_div (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .run   (half_run),
        .tc    (half_tc)
    );

    always_comb begin
        flag_d = '0;
        flag_d[FLAG_CNT_MSB:FLAG_CNT_LSB] = count_q;
        flag_d[FLAG_TURN_BIT] = TURN_EN;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = FIRST_PHASE;
            // Turnaround low phase; the following HIGH sees bit_idx==0 and
            // always returns to LOW, so the turn needs no extra state.
            TURN: if (half_tc) state_d = HIGH;
            LOW:  if (half_tc) state_d = HIGH;
            HIGH: if (half_tc) state_d = (bit_idx_q == count_q) ? DONE : LOW;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            swclk_q    <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_flag_q  <= '0;
        end else begin
            state_q <= state_d;

            if (accept) begin
                count_q   <= clamp_count(cmd_count);
                bit_idx_q <= '0;
                shift_q   <= '0;
                busy_q    <= 1'b1;
            end

            // SWCLK only moves on half-period terminal counts; the sample is
            // taken on the same edge that raises SWCLK.
            if (half_tc) begin
                case (state_q)
                    TURN: swclk_q <= 1'b1;
                    LOW: begin
                        swclk_q                     <= 1'b1;
                        shift_q[bit_idx_q[5:0]]     <= SWDIO_TMS_I;
                        bit_idx_q                   <= bit_idx_q + 7'd1;
                    end
                    HIGH: swclk_q <= 1'b0;
                    default: ;
                endcase
            end

            if (state_q == DONE) begin
                rx_data_q  <= shift_q;
                rx_flag_q  <= flag_d;
                rx_valid_q <= 1'b1;
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_swd_seq_capture.sv
// tb/tb_swd_seq_capture.sv - self-checking bench for swd_seq_capture
module tb_swd_seq_capture;

    localparam int CLK_DIV = 2;
`ifdef SEQ_CAPTURE_TURN_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_count;
    logic        rx_valid;
    logic        rx_ready;
    logic [63:0] rx_data;
    logic [15:0] rx_flag;
    logic        busy;
    logic        SWCLK_TCK_O;
    logic        SWDIO_TMS_T;
    logic        SWDIO_TMS_I = 1'b0;

    swd_seq_capture #(
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_count   (cmd_count),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_data     (rx_data),
        .rx_flag     (rx_flag),
        .busy        (busy),
        .SWCLK_TCK_O (SWCLK_TCK_O),
        .SWDIO_TMS_T (SWDIO_TMS_T),
        .SWDIO_TMS_I (SWDIO_TMS_I)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Target model: counts SWCLK rising edges and presents the bit belonging
    // to the next rising edge on SWDIO.
    int           pulses     = 0;
    int           base       = 0;
    logic [127:0] stim_r     = '0;
    logic         swclk_prev = 1'b0;
    logic         t_low_seen = 1'b0;

    always @(negedge clk) begin
        if (SWCLK_TCK_O === 1'b1 && swclk_prev !== 1'b1) pulses++;
        swclk_prev = SWCLK_TCK_O;
        if (SWDIO_TMS_T !== 1'b1) t_low_seen = 1'b1;
        SWDIO_TMS_I = stim_r[(pulses - base) & 127];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int eff_count(input logic [6:0] c);
        return (c == 0 || c > 64) ? 64 : int'(c);
    endfunction

    task automatic drain();
        int w = 0;
        while (rx_valid !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("drain_result", 64'(rx_valid), 64'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic run_capture(input logic [6:0] c, input logic [63:0] data, input int hold,
                               input bit offer, output logic [63:0] d, output logic [15:0] f,
                               output int lat, output int pul);
        int bad;
        @(negedge clk);
        stim_r = {64'd0, data} << TURN;
        base   = pulses;
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_count = c;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_count = 7'($urandom);
        chk("busy_after_accept", 64'(busy), 64'd1);
        lat = 0;
        while (rx_valid !== 1'b1 && lat < 2000) begin
            rx_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        rx_ready = 1'b0;
        d   = rx_data;
        f   = rx_flag;
        pul = pulses - base;
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            if (offer) begin
                cmd_valid = 1'b1;
                cmd_count = 7'd3;
            end
            @(negedge clk);
            if (rx_valid !== 1'b1 || rx_data !== d || rx_flag !== f || cmd_ready !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        if (hold > 0) chk("backpressure_stable", 64'(bad), 64'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("rx_valid_cleared", 64'(rx_valid), 64'd0);
        chk("busy_cleared", 64'(busy), 64'd0);
        if (offer) begin
            chk("cmd_ready_after_hs", 64'(cmd_ready), 64'd1);
            @(negedge clk);
            cmd_valid = 1'b0;
            chk("accept_after_hs", 64'(busy), 64'd1);
            drain();
        end
    endtask

    typedef struct {
        logic [6:0]  count;
        logic [63:0] data;
        logic [63:0] exp_data;
        logic [15:0] exp_flag;
        int          hold;
        bit          offer;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [63:0] d;
        logic [15:0] f;
        int          lat;
        int          pul;
        int          bad;
        int          w;
        logic [15:0] turn_flag;

        turn_flag = 16'(TURN) << 15;

        vecs[0] = '{7'd8,   64'h4D,                   64'h4D,                   16'h0008, 0,  1'b0};
        vecs[1] = '{7'd0,   64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_FFFF_FFFF,  16'h0040, 0,  1'b0};
        vecs[2] = '{7'd1,   64'hFFFF_FFFF_FFFF_FFFF,  64'h1,                    16'h0001, 0,  1'b0};
        vecs[3] = '{7'd100, 64'hDEAD_BEEF_0123_4567,  64'hDEAD_BEEF_0123_4567,  16'h0040, 0,  1'b0};
        vecs[4] = '{7'd5,   64'hFFFF_FFFF_FFFF_FFF5,  64'h15,                   16'h0005, 20, 1'b1};
        vecs[5] = '{7'd64,  64'h8000_0000_0000_0001,  64'h8000_0000_0000_0001,  16'h0040, 0,  1'b0};
        vecs[6] = '{7'd65,  64'hA5A5_5A5A_C3C3_3C3C,  64'hA5A5_5A5A_C3C3_3C3C,  16'h0040, 0,  1'b0};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_count = '0;
        rx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("reset_rx_valid", 64'(rx_valid), 64'd0);
        chk("reset_rx_data", rx_data, 64'd0);
        chk("reset_rx_flag", 64'(rx_flag), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_swclk", 64'(SWCLK_TCK_O), 64'd0);
        chk("reset_swdio_t", 64'(SWDIO_TMS_T), 64'd1);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_capture(vecs[i].count, vecs[i].data, vecs[i].hold, vecs[i].offer, d, f, lat, pul);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_flag", i), 64'(f), 64'(vecs[i].exp_flag | turn_flag));
            chk($sformatf("vec%0d_latency", i), 64'(lat),
                64'(2 * CLK_DIV * (int'(vecs[i].exp_flag[6:0]) + TURN) + 1));
            chk($sformatf("vec%0d_pulses", i), 64'(pul), 64'(int'(vecs[i].exp_flag[6:0]) + TURN));
        end

        // Reset in the high phase of the 3rd bit of a 16-bit capture.
        @(negedge clk);
        stim_r = {64'd0, 64'hFFFF} << TURN;
        base   = pulses;
        cmd_valid = 1'b1;
        cmd_count = 7'd16;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while ((pulses - base) < 3 + TURN && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("abort_reached_bit3", 64'(SWCLK_TCK_O), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_swclk", 64'(SWCLK_TCK_O), 64'd0);
        chk("abort_swdio_t", 64'(SWDIO_TMS_T), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rx_valid", 64'(rx_valid), 64'd0);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rx_valid !== 1'b0 || SWCLK_TCK_O !== 1'b0) bad++;
        end
        chk("abort_no_result", 64'(bad), 64'd0);
        run_capture(7'd4, 64'hA, 0, 1'b0, d, f, lat, pul);
        chk("post_abort_data", d, 64'hA);
        chk("post_abort_flag", 64'(f), 64'(16'h0004 | turn_flag));

        // Randomised commands against the arithmetic reference model.
        for (int i = 0; i < 15; i++) begin
            logic [6:0]  c;
            logic [63:0] data;
            logic [63:0] mask;
            int          n;
            c    = 7'($urandom_range(0, 127));
            data = {$urandom, $urandom};
            n    = eff_count(c);
            mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
            run_capture(c, data, 0, 1'b0, d, f, lat, pul);
            chk($sformatf("rand%0d_data", i), d, data & mask);
            chk($sformatf("rand%0d_flag", i), 64'(f), 64'(16'(n) | turn_flag));
            chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(2 * CLK_DIV * (n + TURN) + 1));
        end

        chk("swdio_never_driven", 64'(t_low_seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
